stage_mem_lsu: RTL

Memory-stage load/store unit that produces the DMEM read data consumed by the writeback mux. It turns EX/MEM load/store controls into a req/gnt/rvalid transaction on the data-memory bus. It generates store byte-enables and lane replication, and sign- or zero-extends load data. It stalls the pipeline until the access completes.

---
 rtl/stage_mem_lsu.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data-memory bus and aligns/extends load data.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module stage_mem_lsu #(
    parameter int REG_WIDTH      = `REG_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  EX_MEM_mem_read,
    input  logic                  EX_MEM_mem_write,
    input  logic [2:0]            EX_MEM_funct3,
    input  logic [REG_WIDTH-1:0]  EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]  EX_MEM_rs2_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [31:0]           dmem_rdata,
    output logic                  lsu_stall,
    output logic [REG_WIDTH-1:0]  MEM_data_out,
    output logic                  MEM_data_valid,
    output logic                  misalign_exc,
    output logic                  bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = lo[0];
            default:     is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: store_be = 4'b0001 << lo;
            F3_H, F3_HU: store_be = lo[1] ? 4'b1100 : 4'b0011;
            default:     store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            F3_B, F3_BU: store_wdata = {4{rs2[7:0]}};
            F3_H, F3_HU: store_wdata = {2{rs2[15:0]}};
            default:     store_wdata = rs2;
        endcase
    endfunction

    // Bring the addressed byte/half down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (f3)
            F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   load_extend = {24'h000000, sh[7:0]};
            F3_HU:   load_extend = {16'h0000, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lo_q, lo_d;
    logic [REG_WIDTH-1:0]  data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  misalign_q, misalign_d;
    logic                  access_s;

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_cnt_inc_s;
    logic            to_expired_s;
    logic            bus_err_q, bus_err_d;

    assign to_cnt_inc_s = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    assign to_expired_s = (to_cnt_inc_s == TIMEOUT_CYCLES[TO_W-1:0]);
    assign bus_err      = bus_err_q;
`else
    // Without the watchdog the limit has no effect; bus_err stays low.
    localparam logic TO_NEVER = (TIMEOUT_CYCLES < 0);
    assign bus_err = TO_NEVER;
`endif

    assign access_s = EX_MEM_mem_read | EX_MEM_mem_write;

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        lo_d       = lo_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    if (is_misaligned(EX_MEM_funct3, EX_MEM_alu_out[1:0])) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        we_d    = EX_MEM_mem_write;
                        addr_d  = {EX_MEM_alu_out[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d = store_wdata(EX_MEM_funct3, EX_MEM_rs2_data[31:0]);
                        be_d    = EX_MEM_mem_write ? store_be(EX_MEM_funct3, EX_MEM_alu_out[1:0])
                                                   : 4'b1111;
                        f3_d    = EX_MEM_funct3;
                        lo_d    = EX_MEM_alu_out[1:0];
`ifdef LSU_TIMEOUT_EN
                        to_cnt_d = {TO_W{1'b0}};
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
`ifdef LSU_TIMEOUT_EN
                to_cnt_d = to_cnt_inc_s;
`endif
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else if (dmem_rvalid) begin
                        state_d    = ST_DONE;
                        valid_d    = 1'b1;
                        data_out_d = load_extend(f3_q, lo_q, dmem_rdata);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (to_expired_s) begin
                    state_d    = ST_DONE;
                    req_d      = 1'b0;
                    bus_err_d  = 1'b1;
                    data_out_d = {REG_WIDTH{1'b0}};
                end
`endif
                else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
`ifdef LSU_TIMEOUT_EN
                to_cnt_d = to_cnt_inc_s;
`endif
                if (dmem_rvalid) begin
                    state_d    = ST_DONE;
                    valid_d    = 1'b1;
                    data_out_d = load_extend(f3_q, lo_q, dmem_rdata);
                end
`ifdef LSU_TIMEOUT_EN
                else if (to_expired_s) begin
                    state_d    = ST_DONE;
                    bus_err_d  = 1'b1;
                    data_out_d = {REG_WIDTH{1'b0}};
                end
`endif
                else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            f3_q       <= 3'b000;
            lo_q       <= 2'b00;
            data_out_q <= {REG_WIDTH{1'b0}};
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            lo_q       <= lo_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Watchdog counter and bus-error pulse register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_q  <= {TO_W{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`endif

    // The pipeline advances at the end of DONE, so DONE never stalls.
    assign lsu_stall = ((state_q == ST_IDLE) & access_s) | (state_q == ST_REQ) | (state_q == ST_WAIT);

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_be        = be_q;
    assign MEM_data_out   = data_out_q;
    assign MEM_data_valid = valid_q;
    assign misalign_exc   = misalign_q;

endmodule
